// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - encodings, sequencer states and status bit indices for datapath_seq
package datapath_pkg;

    // ALU operation selected by req_aluop
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_MVN = 2'b11
    } alu_op_e;

    // Single-bit shift applied to the B operand
    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    // Writeback source
    typedef enum logic [1:0] {
        VSEL_C      = 2'b00,
        VSEL_PC     = 2'b01,
        VSEL_SXIMM8 = 2'b10,
        VSEL_MDATA  = 2'b11
    } vsel_e;

    // Micro-sequencer states; every non-IDLE state lasts one cycle
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDA  = 3'd1,
        RDB  = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } seq_state_e;

    // Bit positions inside status_out = {V,N,Z}
    localparam int STAT_V = 2;
    localparam int STAT_N = 1;
    localparam int STAT_Z = 0;

endpackage

// File: rtl/datapath_seq_regfile.sv
// rtl/datapath_seq_regfile.sv - parametrised register file, one write port, one combinational read port
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset clearing every register
//   wen, waddr, wdata write port, registered on the rising edge
//   raddr, rdata      combinational read port
module regfile_param #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wen,
    input  logic [$clog2(NREGS)-1:0]  waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [$clog2(NREGS)-1:0]  raddr,
    output logic [DATA_W-1:0]         rdata
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wen) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/datapath_seq.sv
// rtl/datapath_seq.sv - register file + shifter + ALU datapath with an internal read/read/exec/writeback sequencer
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   req_valid/req_ready     request handshake; all req_* fields and sximm8 latched on accept
//   req_rn/rm/rd            A operand, B operand, destination register
//   req_aluop/shift         ALU operation, single-bit shift of B
//   req_asel/bsel/vsel      A=0 select, B=immediate select, writeback source
//   req_write/loads/imm     writeback enable, status update enable, short immediate
//   sximm8                  pre-extended immediate (latched at accept)
//   mdata, pc               writeback sources sampled live in WB
//   c, status_out           ALU result register, {V,N,Z}
//   done                    one-cycle pulse in the WB cycle
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int IMM_W  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [$clog2(NREGS)-1:0]  req_rn,
    input  logic [$clog2(NREGS)-1:0]  req_rm,
    input  logic [$clog2(NREGS)-1:0]  req_rd,
    input  logic [1:0]                req_aluop,
    input  logic [1:0]                req_shift,
    input  logic                      req_asel,
    input  logic                      req_bsel,
    input  logic [1:0]                req_vsel,
    input  logic                      req_write,
    input  logic                      req_loads,
    input  logic [IMM_W-1:0]          req_imm,
    input  logic [DATA_W-1:0]         sximm8,
    input  logic [DATA_W-1:0]         mdata,
    input  logic [DATA_W-1:0]         pc,
    output logic [DATA_W-1:0]         c,
    output logic [2:0]                status_out,
    output logic                      done
);

    localparam int RW  = $clog2(NREGS);
    localparam int MSB = DATA_W - 1;

    seq_state_e        state, state_n;

    // Request fields captured at accept
    logic [RW-1:0]     rn_q, rm_q, rd_q;
    alu_op_e           aluop_q;
    shift_e            shift_q;
    vsel_e             vsel_q;
    logic              asel_q, bsel_q, write_q, loads_q;
    logic [IMM_W-1:0]  imm_q;
    logic [DATA_W-1:0] sximm8_q;

    logic [DATA_W-1:0] a_q, b_q, c_q;
    logic [2:0]        status_q;

    logic [RW-1:0]     rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              rf_wen;
    logic [DATA_W-1:0] wb_data;

    logic [DATA_W-1:0] b_shift, ain, bin, alu_res;
    logic              alu_v;
    logic              accept;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign done      = (state == WB) && !reset;
    assign c          = c_q;
    assign status_out = status_q;

    // The single read port serves rn in RDA and rm in RDB
    assign rf_raddr = (state == RDB) ? rm_q : rn_q;
    assign rf_wen   = (state == WB) && write_q && !reset;

    regfile_param #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .wen   (rf_wen),
        .waddr (rd_q),
        .wdata (wb_data),
        .raddr (rf_raddr),
        .rdata (rf_rdata)
    );

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = RDA;
            RDA:     state_n = RDB;
            RDB:     state_n = EXEC;
            EXEC:    state_n = WB;
            WB:      state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Shifter on the B register
    always_comb begin
        b_shift = b_q;
        case (shift_q)
            SH_LSL1: b_shift = {b_q[MSB-1:0], 1'b0};
            SH_LSR1: b_shift = {1'b0, b_q[MSB:1]};
            SH_ASR1: b_shift = {b_q[MSB], b_q[MSB:1]};
            default: b_shift = b_q;
        endcase
    end

    assign ain = asel_q ? '0 : a_q;
    assign bin = bsel_q ? {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q} : b_shift;

    // ALU; overflow is only meaningful for ADD/SUB
    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        case (aluop_q)
            ALU_ADD: begin
                alu_res = ain + bin;
                alu_v   = (ain[MSB] == bin[MSB]) && (alu_res[MSB] != ain[MSB]);
            end
            ALU_SUB: begin
                alu_res = ain - bin;
                alu_v   = (ain[MSB] != bin[MSB]) && (alu_res[MSB] != ain[MSB]);
            end
            ALU_AND: alu_res = ain & bin;
            default: alu_res = ~bin;
        endcase
    end

    // Writeback mux; the C path uses the c loaded in EXEC, pc/mdata are live
    always_comb begin
        wb_data = c_q;
        case (vsel_q)
            VSEL_PC:     wb_data = pc;
            VSEL_SXIMM8: wb_data = sximm8_q;
            VSEL_MDATA:  wb_data = mdata;
            default:     wb_data = c_q;
        endcase
    end

    // Request capture and operand/result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rn_q     <= '0;
            rm_q     <= '0;
            rd_q     <= '0;
            aluop_q  <= ALU_ADD;
            shift_q  <= SH_NONE;
            vsel_q   <= VSEL_C;
            asel_q   <= 1'b0;
            bsel_q   <= 1'b0;
            write_q  <= 1'b0;
            loads_q  <= 1'b0;
            imm_q    <= '0;
            sximm8_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
        end else begin
            if (accept) begin
                rn_q     <= req_rn;
                rm_q     <= req_rm;
                rd_q     <= req_rd;
                aluop_q  <= alu_op_e'(req_aluop);
                shift_q  <= shift_e'(req_shift);
                vsel_q   <= vsel_e'(req_vsel);
                asel_q   <= req_asel;
                bsel_q   <= req_bsel;
                write_q  <= req_write;
                loads_q  <= req_loads;
                imm_q    <= req_imm;
                sximm8_q <= sximm8;
            end
            if (state == RDA) a_q <= rf_rdata;
            if (state == RDB) b_q <= rf_rdata;
            if (state == EXEC) begin
                c_q <= alu_res;
                if (loads_q) begin
                    status_q[STAT_V] <= alu_v;
                    status_q[STAT_N] <= alu_res[MSB];
                    status_q[STAT_Z] <= (alu_res == '0);
                end
            end
        end
    end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised successor to the single-cycle-controlled datapath.
- Same register file, shifter and ALU structure, generalised in data width, register count and immediate width.
- Adds an internal micro-sequencer: one request handshake runs the full operation (read A, read B, execute, writeback) without an external controller driving loada/loadb/loadc/write per cycle.
- Sits between the instruction decoder/FSM and memory/PC logic of the CPU.

Parameters:
- DATA_W, 16, datapath and register width (>=8).
- NREGS, 8, number of general registers (power of two, >=2); RW = log2(NREGS).
- IMM_W, 5, width of the short ALU immediate; sign-extended to DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  operation request.
- req_ready  out  1  block can accept a request.
- req_rn  in  RW  A-operand register.
- req_rm  in  RW  B-operand register.
- req_rd  in  RW  destination register.
- req_aluop  in  2  00 ADD, 01 SUB, 10 AND, 11 MVN (~B).
- req_shift  in  2  00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1 (MSB fill).
- req_asel  in  1  1: ALU A input = 0.
- req_bsel  in  1  1: ALU B input = sign-extended req_imm.
- req_vsel  in  2  writeback source: 00 C, 01 pc, 10 sximm8, 11 mdata.
- req_write  in  1  perform register writeback.
- req_loads  in  1  update status.
- req_imm  in  IMM_W  short immediate.
- sximm8  in  DATA_W  pre-extended 8-bit immediate, captured at accept.
- mdata  in  DATA_W  memory data, sampled live in WB.
- pc  in  DATA_W  program counter, sampled live in WB.
- c  out  DATA_W  ALU result register.
- status_out  out  3  {V,N,Z}.
- done  out  1  one-cycle pulse in WB.

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE.
  - A, B, c, status_out, all registers = 0.
  - done = 0.
  - req_ready = 0 while reset is high, 1 in the first cycle after reset.
- req_ready = (state==IDLE) && !reset. Accept on a clk edge with req_valid && req_ready; all req_* fields and sximm8 are latched at accept. Fields are don't-care when not accepting.
- States: IDLE -> RDA -> RDB -> EXEC -> WB -> IDLE; every non-IDLE state lasts exactly one cycle.
  - RDA: A <= R[rn].
  - RDB: B <= R[rm].
  - EXEC: c <= ALU(Ain, Bin).
    - Ain = asel ? 0 : A.
    - Bin = bsel ? sext(imm) : shift(B).
    - If loads: status_out <= {V,N,Z}.
  - WB: done = 1. If write: R[rd] <= vsel mux (C uses the c just loaded) at the end of the WB cycle.
- Latency: accept at edge 0; done high in cycle 4; register visible to the next op's RDA. Throughput: one op per 5 cycles.
- Arithmetic: results are truncated modulo 2^DATA_W.
  - Z = (result==0).
  - N = result[DATA_W-1].
  - V = signed overflow for ADD/SUB; 0 for AND/MVN.
- Shifter: single-bit shifts only. LSR fills 0; ASR replicates the MSB.
- rd may equal rn or rm; operands are read in RDA/RDB before WB, so the old value is used.
- write=0: no register changes (compare-only). loads=0: status_out holds.
- Reset mid-operation (any non-IDLE state): abort, no register write, no done pulse; return to IDLE.
- A, B, c and status_out hold their values between operations.

Decomposition:
- Package datapath_pkg holds:
  - ALU op, shift and vsel encodings as typedef enums.
  - The sequencer state enum (IDLE, RDA, RDB, EXEC, WB).
  - The status bit indices (V=2, N=1, Z=0).
- One natural sub-module: regfile_param #(DATA_W, NREGS), with 1 write port, 1 combinational read port, and synchronous reset clearing all registers.
- Shifter and ALU are combinational logic inside the top module.

Test Plan:
- Reset: hold reset 2 cycles mid-stream -> c=0, status_out=000, done=0, req_ready=0 during reset and 1 in the next cycle; all registers read 0.
- MOV immediate: vsel=10, sximm8=0x0042, rd=3, write=1 -> done 4 cycles after accept. Then ADD asel=1, rm=3, shift=00 -> c=0x0042.
- ADD with shift: R1=7, R2=3, ADD rn=1, rm=2, shift=01, loads=1 -> c=0x000D, status_out=000.
- SUB overflow: R0=0x8000, R1=1, SUB rn=0, rm=1, loads=1 -> c=0x7FFF, status_out=100.
- Compare-only: SUB rn=2, rm=2, write=0, loads=1 -> status_out=001; R[rd] unchanged. Then assert reset during EXEC of a write op -> no done pulse, destination register cleared to 0 by reset, req_ready=1 afterwards.
- Wide configuration: DATA_W=32, NREGS=16; R15=0x80000000, MVN-free ADD asel=1, rm=15, shift=11 -> c=0xC0000000, N=1; bsel=1, imm=5'b10000 with asel=1 -> c=0xFFFFFFF0.
